i2s_fifo_tx: RTL

// - Consumer end of the sample FIFO: drains WIDTH-bit signed PCM words and serialises them as stereo I2S to the DAC.
// - Sits between the mixer-output FIFO and the board audio codec.
// - Words are alternately left/right (first word after enable = left).
// - Underrun is detected and flagged; output then degrades gracefully, never stalls.

---
 rtl/i2s_pkg.sv | 24 ++
 rtl/i2s_bclk_gen.sv | 70 +++++++
 rtl/i2s_fifo_tx.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Shared types and helpers for the I2S FIFO transmitter.
//   state_e      : transmitter FSM states (IDLE, RUN, DRAIN)
//   LEFT / RIGHT : word-select (i2s_lrclk) levels for the two channels
//   div_cnt_w()  : width of the BCLK divider counter for a given BCLK_DIV
// -----------------------------------------------------------------------------
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  // $clog2(1) is 0, so keep at least one bit for degenerate dividers.
  function automatic int unsigned div_cnt_w(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// -----------------------------------------------------------------------------
// i2s_bclk_gen
// Bit-clock generator. Counts 0..BCLK_DIV-1 and toggles bclk at the terminal
// count, so bclk has a period of 2*BCLK_DIV clk cycles. The fall/rise strobes
// are high in the clk cycle whose closing edge makes bclk fall/rise, letting
// the owner update outputs on the same edge that drops bclk.
// Parameters:
//   BCLK_DIV : clk cycles per bclk half-period (>= 2)
// Ports:
//   clk  in  : system clock
//   rst  in  : synchronous, active-high reset
//   run  in  : enable; while low the counter is cleared and bclk held at 0
//   bclk out : bit clock
//   fall out : one-cycle strobe, bclk goes 1->0 at the next clk edge
//   rise out : one-cycle strobe, bclk goes 0->1 at the next clk edge
// -----------------------------------------------------------------------------
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bclk,
  output logic fall,
  output logic rise
);

  localparam int unsigned      CW       = div_cnt_w(BCLK_DIV);
  localparam logic [CW-1:0]    CNT_LAST = CW'(BCLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bclk_q, bclk_d;
  logic          term;

  // NOTE: every variable assigned in an always_comb gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    term   = run && (cnt_q == CNT_LAST);
    cnt_d  = cnt_q;
    bclk_d = bclk_q;
    if (!run) begin
      cnt_d  = '0;
      bclk_d = 1'b0;
    end else if (term) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk = bclk_q;
  assign fall = term &&  bclk_q;
  assign rise = term && !bclk_q;

endmodule

// File: rtl/i2s_fifo_tx.sv
// -----------------------------------------------------------------------------
// i2s_fifo_tx
// Drains WIDTH-bit PCM words from a FIFO and serialises them as stereo I2S
// (left first, MSB first, one-bit delay after each word-select change).
// An empty FIFO at fetch time raises a one-cycle underrun pulse and the slot
// carries a substitute word; the serial stream never stalls.
// Build option:
//   I2S_TX_HOLD_LAST_EN defined   : underrun slot repeats the last word read
//                                   (0 if none since reset)
//   I2S_TX_HOLD_LAST_EN undefined : underrun slot is silence (0)
// Parameters:
//   WIDTH    : bits per sample word and per I2S slot
//   BCLK_DIV : clk cycles per bclk half-period (>= 2)
// Ports:
//   clk        in  : system clock
//   rst        in  : synchronous, active-high reset
//   en         in  : run request
//   fifo_rd    out : one-cycle FIFO read strobe
//   fifo_dout  in  : FIFO data, valid the cycle after fifo_rd
//   fifo_empty in  : FIFO empty, sampled in the cycle fifo_rd would assert
//   i2s_bclk   out : bit clock
//   i2s_lrclk  out : word select (0 = left, 1 = right)
//   i2s_sdata  out : serial data
//   underrun   out : one-cycle pulse when a fetch found the FIFO empty
//   busy       out : high while not IDLE
// -----------------------------------------------------------------------------
module i2s_fifo_tx
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned BCLK_DIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             fifo_rd,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             i2s_bclk,
  output logic             i2s_lrclk,
  output logic             i2s_sdata,
  output logic             underrun,
  output logic             busy
);

  localparam int unsigned   BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             run;
  logic             bclk_fall;
  logic             bclk_rise_unused;

  logic [BW-1:0]    bit_q, bit_d;        // falls since the last word-select change
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             started_q, started_d; // first fall since leaving IDLE seen
  logic             last_q, last_d;       // final right LSB is on the wire
  logic             rd_pend_q;            // fifo_dout is valid this cycle
  logic [WIDTH-1:0] fill_word;

  logic             slot_start;
  logic             drain_stop;
  logic             fetch;

  // Only falls matter here: all outputs move on falls, the codec samples on rises.
  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .bclk (i2s_bclk),
    .fall (bclk_fall),
    .rise (bclk_rise_unused)
  );

  // A slot begins on the word-select fall. The very first fall after IDLE
  // counts as one too, which forces left and issues the first fetch.
  assign slot_start = bclk_fall && (!started_q || (bit_q == BIT_LAST));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (en) state_d = RUN;
      RUN:   if (!en) state_d = DRAIN;
      DRAIN: begin
        if (last_q && bclk_fall)                 state_d = IDLE;
        else if (en && !last_q && !drain_stop)   state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    run        = busy;
    // While draining, the slot that would start a new left word is not
    // fetched; it only carries the right LSB for one bit period.
    drain_stop = slot_start && (state_q == DRAIN) && (!started_q || (lrclk_q == RIGHT));
    fetch      = slot_start && busy && !drain_stop;
    fifo_rd    = fetch && !fifo_empty && !rst;
    underrun   = fetch &&  fifo_empty && !rst;
  end

  // -------------------------------------------------- underrun fill word
`ifdef I2S_TX_HOLD_LAST_EN
  logic [WIDTH-1:0] last_word_q;

  always_ff @(posedge clk) begin
    if (rst)            last_word_q <= '0;
    else if (rd_pend_q) last_word_q <= fifo_dout;
  end

  assign fill_word = last_word_q;
`else
  assign fill_word = '0;
`endif

  // ------------------------------------------------------------ datapath
  always_comb begin
    bit_d     = bit_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    started_d = started_q;
    last_d    = last_q;

    if (rd_pend_q)     hold_d = fifo_dout;
    else if (underrun) hold_d = fill_word;

    if (bclk_fall) begin
      if (last_q) begin
        // Right LSB has had its bit period; return the wire to idle.
        bit_d     = '0;
        lrclk_d   = LEFT;
        sdata_d   = 1'b0;
        shift_d   = '0;
        started_d = 1'b0;
        last_d    = 1'b0;
      end else if (slot_start) begin
        // Word select flips while the previous word's LSB goes out.
        bit_d     = '0;
        lrclk_d   = started_q ? ~lrclk_q : LEFT;
        started_d = 1'b1;
        sdata_d   = shift_q[WIDTH-1];
        shift_d   = shift_q << 1;
        last_d    = drain_stop;
      end else if (bit_q == '0) begin
        // One bit after the word-select change: the new word's MSB.
        sdata_d   = hold_q[WIDTH-1];
        shift_d   = hold_q << 1;
        bit_d     = bit_q + 1'b1;
      end else begin
        sdata_d   = shift_q[WIDTH-1];
        shift_d   = shift_q << 1;
        bit_d     = bit_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q     <= '0;
      lrclk_q   <= LEFT;
      sdata_q   <= 1'b0;
      shift_q   <= '0;
      hold_q    <= '0;
      started_q <= 1'b0;
      last_q    <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      bit_q     <= bit_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      started_q <= started_d;
      last_q    <= last_d;
      rd_pend_q <= fifo_rd;
    end
  end

  assign i2s_lrclk = lrclk_q;
  assign i2s_sdata = sdata_q;

endmodule
